// File: rtl/alu_cmd_issuer.sv
// Command issuer for an external combinational 8-bit ALU: buffers commands in a
// FIFO, issues one at a time, and returns each result with a sequence tag.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_dz,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [3:0] SEL_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  typedef struct packed {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [3:0]       sel;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] tag_q, tag_d, cur_tag_q, cur_tag_d;
  logic             cur_dz_q, cur_dz_d;
  logic [7:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             res_valid_q, res_valid_d, res_dz_q, res_dz_d;
  logic [7:0]       res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  cmd_t mem_q [DEPTH];
  cmd_t head;
  logic push, pop, empty;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q < FULL);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  // NOTE: FIFO storage carries no reset; emptiness is defined solely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel, tag: tag_q};
  end

  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    cur_tag_d   = cur_tag_q;
    cur_dz_d    = cur_dz_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    res_dz_d    = res_dz_q;
    unique case (state_q)
      IDLE: if (!empty) pop = 1'b1;
      ISSUE: begin
        res_data_d  = alu_result;
        res_tag_d   = cur_tag_q;
        res_dz_d    = cur_dz_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        if (!empty) pop = 1'b1;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Both IDLE and HOLD issue the head entry the same way.
    if (pop) begin
      alu_a_d   = head.a;
      alu_b_d   = head.b;
      alu_sel_d = head.sel;
      cur_tag_d = head.tag;
      cur_dz_d  = (head.sel == SEL_DIV) && (head.b == 8'h00);
      state_d   = ISSUE;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    tag_d    = push ? tag_q + TAG_W'(1)    : tag_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tag_q       <= '0;
      cur_tag_q   <= '0;
      cur_dz_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_q       <= tag_d;
      cur_tag_q   <= cur_tag_d;
      cur_dz_q    <= cur_dz_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      res_dz_q    <= res_dz_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign res_dz    = res_dz_q;
  assign busy      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: table vectors plus directed sequences,
// with a result scoreboard fed at command accept and drained at result handshake.
module tb_alu_cmd_issuer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk, rst;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [3:0]       cmd_sel;
  logic [7:0]       alu_a, alu_b, alu_result;
  logic [3:0]       alu_sel;
  logic             res_valid, res_ready, res_dz, busy;
  logic [7:0]       res_data;
  logic [TAG_W-1:0] res_tag;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_dz(res_dz), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the external combinational ALU.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] sel);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (sel)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return p[7:0];
      4'b0011: return (b == 8'h00) ? 8'h00 : a / b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
    logic             dz;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] exp_data;
    logic       exp_dz;
  } vec_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_checks = 0;
  int               n_fail = 0;
  logic [TAG_W-1:0] exp_tag;
  vec_t             tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Results are compared on the falling edge before the handshake edge.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got tag 0x%0h, expected no result", res_tag);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", 32'(res_data), 32'(mon_e.data));
        check("res_tag",  32'(res_tag),  32'(mon_e.tag));
        check("res_dz",   32'(res_dz),   32'(mon_e.dz));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] ed, input logic edz);
    int waited = 0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    while (!cmd_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      sb.push_back('{ed, exp_tag, edz});
      exp_tag++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    send(a, b, sel, alu_f(a, b, sel), (sel == 4'b0011) && (b == 8'h00));
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    sb.delete();
    exp_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sb.size() == 0 && !busy), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h7F, 8'h01, 4'b0000, 8'h80, 1'b0};
    tbl[1] = '{8'h10, 8'h20, 4'b0001, 8'hF0, 1'b0};
    tbl[2] = '{8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b0};
    tbl[3] = '{8'h0F, 8'hA0, 4'b1001, 8'hAF, 1'b0};
    tbl[4] = '{8'hFF, 8'h0F, 4'b1010, 8'hF0, 1'b0};
    tbl[5] = '{8'h55, 8'h00, 4'b0011, 8'h00, 1'b1};
    tbl[6] = '{8'h64, 8'h05, 4'b0011, 8'h14, 1'b0};
    tbl[7] = '{8'h12, 8'h10, 4'b0010, 8'h20, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; exp_tag = '0;
    #3;
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_sel",   32'(alu_sel),   32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_tag",   32'(res_tag),   32'd0);
    check("rst_res_dz",    32'(res_dz),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Single op with exact latency.
    res_ready = 1'b1;
    cmd_a = 8'h0F; cmd_b = 8'h01; cmd_sel = 4'b0000; cmd_valid = 1'b1;
    sb.push_back('{8'h10, exp_tag, 1'b0});
    exp_tag++;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("k1_alu_a",     32'(alu_a),     32'h0F);
    check("k1_alu_sel",   32'(alu_sel),   32'h0);
    check("k1_res_valid", 32'(res_valid), 32'd0);
    @(posedge clk); #1;
    check("k2_res_valid", 32'(res_valid), 32'd1);
    check("k2_res_data",  32'(res_data),  32'h10);
    check("k2_res_tag",   32'(res_tag),   32'd0);
    check("k2_res_dz",    32'(res_dz),    32'd0);
    wait_drain();

    // Table vectors, streamed with res_ready high.
    for (int i = 0; i < 8; i++) send(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].exp_data, tbl[i].exp_dz);
    wait_drain();

    // Fill with backpressure, then release and push the sixth.
    do_reset();
    for (int i = 0; i < 5; i++) send(8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b0);
    cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_sel = 4'b1000; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_res_data",  32'(res_data),  32'h30);
      check("hold_res_tag",   32'(res_tag),   32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    send(8'hF0, 8'h3C, 4'b1000, 8'h30, 1'b0);
    for (int i = 0; i < 10; i++)
      send_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 4'($urandom_range(0, 3)));
    wait_drain();

    // Tag wrap over 17 commands.
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_op(8'(i * 7), 8'(i + 1), 4'b0000);
    wait_drain();

    // Reset in HOLD with three commands queued.
    do_reset();
    for (int i = 0; i < 4; i++) send_op(8'(i + 1), 8'h02, 4'b0000);
    begin
      int n = 0;
      while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    check("pre_rst_res_valid", 32'(res_valid), 32'd1);
    #2 rst = 1'b1;
    sb.delete();
    exp_tag = '0;
    #1;
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_alu_a",     32'(alu_a),     32'd0);
    check("mid_rst_alu_b",     32'(alu_b),     32'd0);
    check("mid_rst_res_data",  32'(res_data),  32'd0);
    check("mid_rst_res_tag",   32'(res_tag),   32'd0);
    @(posedge clk); #1 rst = 1'b0;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    send(8'h33, 8'h11, 4'b0001, 8'h22, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
Initiator side of the 8-bit ALU operand interface (A, B, 4-bit select in, 8-bit result out).
- Accepts operation commands over a valid/ready input and buffers them in a small FIFO.
- Drives registered operands and select onto an external combinational 8-bit ALU, one operation at a time.
- Captures the ALU result and presents it with a sequence tag on a valid/ready output.
- Sits between a command source (test sequencer or controller) and the ALU.

Parameters:
DEPTH, 4, command FIFO entries; power of two, at least 2.
TAG_W, 4, width of the sequence tag; wraps modulo 2^TAG_W.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_sel  input  4  ALU operation select, same encoding as the ALU
alu_a  output  8  registered operand A to the ALU
alu_b  output  8  registered operand B to the ALU
alu_sel  output  4  registered select to the ALU
alu_result  input  8  combinational result from the ALU
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  8  captured ALU result
res_tag  output  TAG_W  tag of the command that produced res_data
res_dz  output  1  set when the command was select 4'b0011 with B == 0
busy  output  1  high when state is not IDLE or the FIFO is non-empty

Behaviour:
- Reset (async assert, any state): FIFO emptied and pending commands discarded; count, pointers and tag counter cleared to 0; state IDLE.
- Output values during reset: alu_a = 0, alu_b = 0, alu_sel = 0, res_valid = 0, res_data = 0, res_tag = 0, res_dz = 0, busy = 0, cmd_ready = 1 after reset releases.
- Command accept:
  - Fires on a rising edge with cmd_valid & cmd_ready.
  - Writes {cmd_a, cmd_b, cmd_sel, tag} into the FIFO, then increments the tag counter (wraps 2^TAG_W-1 -> 0).
- cmd_ready = (count < DEPTH), registered-count based. There is no same-cycle bypass into a full FIFO.
- Simultaneous accept and pop in one cycle: count unchanged, both pointers advance (pointers wrap modulo DEPTH).
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, register alu_a/alu_b/alu_sel from it, latch its tag and dz flag internally -> ISSUE. Otherwise stay in IDLE; alu_* hold their last value.
  - ISSUE (exactly one cycle): res_data <= alu_result, res_tag <= latched tag, res_dz <= latched dz, res_valid <= 1 -> HOLD.
  - HOLD: res_valid = 1; res_data, res_tag and res_dz are held stable while res_ready = 0.
    - On res_valid & res_ready with FIFO non-empty: pop the next command, register alu_*, clear res_valid -> ISSUE.
    - On res_valid & res_ready with FIFO empty: clear res_valid -> IDLE.
- res_dz is computed from cmd_sel == 4'b0011 and cmd_b == 0 at pop time. res_data still carries the ALU's value (0x00 for divide-by-zero).
- Latency:
  - Command accepted at edge k into an empty, idle block gives res_valid = 1 after edge k+2.
  - With res_ready held high, sustained throughput is one result per 2 cycles.
- Results leave strictly in acceptance order; no command is dropped or duplicated.
- Inputs are sampled only on accept; cmd_* may change freely when no handshake occurs.
- Arithmetic: the tag counter is TAG_W bits unsigned; no other arithmetic inside the issuer.

Test Plan:
- Single op: after reset, accept A=0x0F, B=0x01, sel=0000 at edge k -> alu_a=0x0F and alu_sel=0000 after edge k+1; res_valid=1, res_data=0x10, res_tag=0, res_dz=0 after edge k+2.
- Fill and backpressure:
  - Hold res_ready=0 and push 6 commands (sel=1000, A=0xF0, B=0x3C).
  - Required: first result 0x30 is held stable, 5 commands are accepted (1 in flight + 4 buffered), cmd_ready=0 on the 6th.
  - Then raise res_ready -> the 5 results appear in order with tags 0..4.
- Divide-by-zero: sel=0011, A=0x55, B=0x00 -> res_data=0x00, res_dz=1. Then sel=0011, A=0x64, B=0x05 -> res_data=0x14, res_dz=0.
- Tag wrap: 17 sequential commands -> res_tag sequence 0..15, 0.
- Simultaneous push/pop at full: with count=4 and a result handshake popping the FIFO while cmd_valid=1 -> command accepted the next cycle once cmd_ready rises, count returns to 4, and no loss or reordering occurs.
- Reset mid-operation: assert rst in HOLD with 3 commands queued -> res_valid=0, busy=0, all outputs 0 immediately. After release, a new command yields res_tag=0.
